// File: rtl/seven_seg_mux_hex.sv
// Time-multiplexed N-digit hex seven-segment driver with frame-boundary double buffering.
// Drives active-low cathodes and active-low per-digit anodes; all outputs are registered.
module seven_seg_mux_hex #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter bit LZ_BLANK    = 1'b0,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]    LAST_PRESC = PW'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] pend_val, act_val;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
    logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
    logic                    wrap_q;

    logic                    presc_last;
    logic                    wrap;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    dp_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // A digit is zero-blanked when it and every digit above it hold zero.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run & (act_val[4*k +: 4] == 4'h0);
            lz_mask[k] = LZ_BLANK && (k > 0) && zero_run;
        end
    end

    always_comb begin
        presc_last = (presc == LAST_PRESC);
        wrap       = en && presc_last && (idx == LAST_IDX);
        cur_nib    = act_val[idx*4 +: 4];
        cur_blank  = act_blank[idx] | lz_mask[idx];
        an_d       = '1;
        seg_d      = 7'b1111111;
        dp_d       = 1'b1;
        if (en) begin
            an_d = ~(NUM_DIGITS'(1) << idx);
            if (!cur_blank) begin
                seg_d = hex_to_seg(cur_nib);
                dp_d  = ~act_dp[idx];
            end
        end
    end

    // load is a single-cycle strobe with no handshake: value/dp_in/blank_in are
    // sampled on every edge where load=1 and always accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            act_val    <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            wrap_q     <= 1'b0;
            an         <= '1;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            if (en) begin
                if (presc_last) begin
                    presc <= '0;
                    idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
            // A load coinciding with the wrap bypasses pending so it shows this frame.
            if (wrap) begin
                act_val   <= load ? value    : pend_val;
                act_dp    <= load ? dp_in    : pend_dp;
                act_blank <= load ? blank_in : pend_blank;
            end
            wrap_q     <= wrap;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
            digit_idx  <= idx;
            frame_tick <= en & wrap_q;
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_hex.sv
// Bench for seven_seg_mux_hex: two instances (leading-zero blanking off/on) share stimulus;
// a cycle-level reference model fills an expected queue that a negedge monitor drains.
module tb_seven_seg_mux_hex;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg0;
    logic       dp0;
    logic [6:0] seg1;
    logic       dp1;
    logic [1:0] idx;
    logic       ft;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic clk;
  logic rst;
  logic en;
  logic load;
  logic [4*N-1:0] value;
  logic [N-1:0] dp_in;
  logic [N-1:0] blank_in;

  logic [N-1:0] an0, an1;
  logic [6:0]   seg0, seg1;
  logic         dp0, dp1;
  logic [1:0]   idx0, idx1;
  logic         ft0, ft1;

  seven_seg_mux_hex #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .an(an0), .seg(seg0), .dp(dp0), .digit_idx(idx0), .frame_tick(ft0)
  );

  seven_seg_mux_hex #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .an(an1), .seg(seg1), .dp(dp1), .digit_idx(idx1), .frame_tick(ft1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // reference model state
  int           ecount;
  logic [15:0]  m_pend_val, m_act_val;
  logic [3:0]   m_pend_dp, m_act_dp;
  logic [3:0]   m_pend_blank, m_act_blank;
  logic         m_prev_wrap;
  logic         m_wrap;
  int           m_digit;
  logic [3:0]   m_nib;
  logic         m_blank0, m_blank1;
  exp_t         m_e;

  logic [EW-1:0] exp_q[$];
  int checks;
  int errors;

  always @(posedge clk) begin
    if (rst) begin
      m_e = '{an: 4'hF, seg0: 7'h7F, dp0: 1'b1, seg1: 7'h7F, dp1: 1'b1, idx: 2'd0, ft: 1'b0};
      ecount       = 0;
      m_pend_val   = '0;
      m_act_val    = '0;
      m_pend_dp    = '0;
      m_act_dp     = '0;
      m_pend_blank = '0;
      m_act_blank  = '0;
      m_prev_wrap  = 1'b0;
    end else begin
      m_digit  = (ecount / DIV) % N;
      m_nib    = 4'((m_act_val >> (4 * m_digit)) & 16'hF);
      m_blank0 = m_act_blank[m_digit];
      m_blank1 = m_act_blank[m_digit] || (m_digit > 0 && (m_act_val >> (4 * m_digit)) == 0);
      m_e.idx  = 2'(m_digit);
      m_e.an   = en ? ~(4'b0001 << m_digit) : 4'hF;
      m_e.seg0 = (en && !m_blank0) ? seg_tbl[m_nib] : 7'h7F;
      m_e.dp0  = (en && !m_blank0) ? ~m_act_dp[m_digit] : 1'b1;
      m_e.seg1 = (en && !m_blank1) ? seg_tbl[m_nib] : 7'h7F;
      m_e.dp1  = (en && !m_blank1) ? ~m_act_dp[m_digit] : 1'b1;
      m_e.ft   = en && m_prev_wrap;
      m_wrap   = en && ((ecount % FRAME) == FRAME - 1);
      m_prev_wrap = m_wrap;
      if (en) ecount = ecount + 1;
      if (m_wrap) begin
        m_act_val   = load ? value    : m_pend_val;
        m_act_dp    = load ? dp_in    : m_pend_dp;
        m_act_blank = load ? blank_in : m_pend_blank;
      end
      if (load) begin
        m_pend_val   = value;
        m_pend_dp    = dp_in;
        m_pend_blank = blank_in;
      end
    end
    exp_q.push_back(EW'(m_e));
  end

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_t'(exp_q.pop_front());
      check("an0",  32'(an0),  32'(mon_e.an));
      check("an1",  32'(an1),  32'(mon_e.an));
      check("seg0", 32'(seg0), 32'(mon_e.seg0));
      check("dp0",  32'(dp0),  32'(mon_e.dp0));
      check("seg1", 32'(seg1), 32'(mon_e.seg1));
      check("dp1",  32'(dp1),  32'(mon_e.dp1));
      check("idx0", 32'(idx0), 32'(mon_e.idx));
      check("idx1", 32'(idx1), 32'(mon_e.idx));
      check("ft0",  32'(ft0),  32'(mon_e.ft));
      check("ft1",  32'(ft1),  32'(mon_e.ft));
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load_now(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value    = v;
    dp_in    = d;
    blank_in = b;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    pulse_load_now(v, d, b);
  endtask

  // Stops at the negedge just before the edge where the frame position equals p.
  task automatic wait_phase(input int p);
    int n;
    n = 0;
    @(negedge clk);
    while ((ecount % FRAME) != p && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((ecount % FRAME) != p) begin
      errors++;
      $display("FAIL wait_phase: position %0d expected %0d", ecount % FRAME, p);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    en       = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    blank_in = '0;

    idle(3);
    rst = 1'b0;
    idle(2 * FRAME + 4);

    load_once(16'h0123, 4'h0, 4'h0);
    idle(2 * FRAME);
    load_once(16'h89AB, 4'h0, 4'h0);
    idle(2 * FRAME);
    load_once(16'hCDEF, 4'h0, 4'h0);
    idle(2 * FRAME);

    wait_phase(9);
    pulse_load_now(16'hFFFF, 4'h0, 4'h0);
    idle(2 * FRAME);
    wait_phase(FRAME - 1);
    pulse_load_now(16'h1234, 4'hA, 4'h0);
    idle(2 * FRAME);

    load_once(16'h0050, 4'b0001, 4'h0);
    idle(2 * FRAME);
    load_once(16'h0000, 4'b0000, 4'h0);
    idle(2 * FRAME);
    load_once(16'h7C0E, 4'b0110, 4'b0100);
    idle(2 * FRAME);

    wait_phase(5);
    en = 1'b0;
    idle(10);
    en = 1'b1;
    idle(FRAME + 4);
    en = 1'b0;
    load_once(16'h4321, 4'h5, 4'h0);
    idle(6);
    en = 1'b1;
    idle(2 * FRAME);

    load_once(16'h5A5A, 4'hF, 4'h0);
    idle(2 * FRAME);
    wait_phase(9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(FRAME + 4);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 119) == 0);
      en       = ($urandom_range(0, 7) != 0);
      load     = ($urandom_range(0, 5) == 0);
      value    = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in    = 4'($urandom_range(0, 15));
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
    end
    @(negedge clk);
    rst  = 1'b0;
    en   = 1'b1;
    load = 1'b0;
    idle(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux_hex.md
Name: seven_seg_mux_hex

Overview:
- Time-multiplexed N-digit hexadecimal seven-segment display driver, the parametrised successor to the single-digit hex decoder.
- Latches a packed multi-nibble value with per-digit decimal points and blanking, then scans digits at a programmable refresh rate.
- Drives the shared active-low cathodes and per-digit active-low anodes of the board display, 100 MHz system clock.
- Frame-boundary double buffering gives tear-free updates.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clock cycles each digit is lit (>=2); 100000 gives 1 ms per digit at 100 MHz.
- LZ_BLANK, 0, 1 = blank leading zero digits above the most significant nonzero digit.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, scan enable; 0 blanks all anodes and freezes the scan.
- load, input, 1, single-cycle strobe that captures value/dp_in/blank_in.
- value, input, 4*NUM_DIGITS, packed hex nibbles; digit k = value[4k+3:4k], digit 0 rightmost.
- dp_in, input, NUM_DIGITS, decimal point request per digit (1 = lit).
- blank_in, input, NUM_DIGITS, force digit dark (1 = blank).
- an, output, NUM_DIGITS, anode enables, active low.
- seg, output, 7, cathodes {a,b,c,d,e,f,g}, seg[6]=a, active low.
- dp, output, 1, decimal point cathode, active low.
- digit_idx, output, clog2(NUM_DIGITS) (min 1), index of digit currently driven.
- frame_tick, output, 1, one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Decided: one clock, clk; rst synchronous, active-high.
- Reset values: an all ones, seg 7'b1111111, dp 1, digit_idx 0, frame_tick 0. Prescaler, pending buffer and active buffer are cleared to zero.
- Prescaler counts 0..REFRESH_DIV-1 while en=1. At terminal count it returns to 0 and the scan index advances by one. After NUM_DIGITS-1 the index wraps to 0.
- frame_tick = 1 for exactly the cycle in which the index wraps to 0.
- Double buffering:
  - load=1 copies value/dp_in/blank_in into the pending buffer.
  - The active buffer takes the pending contents on each frame wrap.
  - If load and the wrap occur in the same cycle, the new load data goes straight to both buffers. The new data is displayed starting with digit 0 of the frame that begins then.
- Outputs are registered. an/seg/dp/digit_idx reflect the scan index and active buffer one cycle after the index changes.
- an is ~(1<<idx). Exactly one anode is low while en=1 and not in reset.
- Decode table (hex to seg), active low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blanked digit: the anode is still driven, seg=1111111, dp=1. A digit is blanked if blank_in[k]=1, or if LZ_BLANK=1, k>0, and all nibbles k..NUM_DIGITS-1 are zero. Digit 0 is never zero-blanked.
- dp = ~dp_in[k] unless the digit is blanked.
- en=0:
  - Prescaler and index hold.
  - an all ones, seg/dp all ones, frame_tick 0.
  - load still captures into pending. Active updates only at the next wrap.
  - On re-enable, scanning resumes from the held index and prescaler.
- Reset mid-scan: within one cycle all outputs return to reset values and both buffers are cleared. The first digit-0 drive appears on the first edge after rst deasserts.
- No combinational path from inputs to outputs.

Test Plan:
- Reset and scan order (NUM_DIGITS=4, REFRESH_DIV=4): hold rst 3 cycles with en=1, release, and check:
  - an sequence 1110,1101,1011,0111 with each pattern held 4 cycles;
  - frame_tick pulses every 16 cycles, aligned with the return to 1110;
  - seg=0000001 on all digits.
- Decode sweep: load value=16'h0123, wait one frame, check seg 0000110, 0010010, 1001111, 0000001 on digits 0..3. Repeat with 16'h89AB, 16'hCDEF and compare all 16 patterns against the table.
- Tear-free update: load 16'hFFFF mid-frame while digit 2 is lit. Digits 2-3 must still show the old data for the rest of that frame; all digits show F (0111000) from the next digit-0 onward. Repeat with load in the exact wrap cycle: the new data must show at that digit 0.
- Blanking and dp: LZ_BLANK=1, value=16'h0050, dp_in=4'b0001, blank_in=0. Check:
  - digit 3: seg=1111111, dp=1;
  - digit 2: seg=1111111, dp=1;
  - digit 1: seg=0100100, dp=1;
  - digit 0: seg=0000001, dp=0.
  Then value=0: only digit 0 is lit, showing 0000001.
- Enable gating: drop en for 10 cycles mid-digit. an=1111, prescaler frozen, no frame_tick. On restoring en, the same digit resumes for its remaining cycles.
- Reset mid-operation: assert rst for 1 cycle during digit 2 with data loaded. The next cycle shows an=1111, seg=1111111. After release, digit 0 shows 0000001, confirming the buffers were cleared.
